// File: rtl/fetch_prefetch_queue.sv
// Fetch prefetch queue: sequential req/ack instruction fetch into a small PC+instr FIFO,
// with head presented to decode and flush/refetch on an Execute-stage redirect.
module fetch_prefetch_queue #(
  parameter int unsigned           word_width = 32,
  parameter int unsigned           depth      = 4,
  parameter logic [word_width-1:0] reset_pc   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [word_width-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [word_width-1:0] imem_rdata,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [word_width-1:0] PCTargetE,
  output logic                  validF,
  output logic [word_width-1:0] instrF,
  output logic [word_width-1:0] PCF,
  output logic [word_width-1:0] PCPlus4F
);

  localparam int unsigned           AW   = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned           CW   = AW + 1;
  localparam logic [word_width-1:0] STEP = word_width'(4);

  logic                  r_req;
  logic [word_width-1:0] r_addr;
  logic [word_width-1:0] r_fetch_pc;
  logic [CW-1:0]         r_count;
  logic                  r_discard;
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [word_width-1:0] r_pc_q    [depth];
  logic [word_width-1:0] r_instr_q [depth];

  logic                  w_ack;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_slot_free;
  logic                  w_issue;
  logic                  w_valid;
  logic [word_width-1:0] w_target;
  logic [CW-1:0]         w_count_next;

  // Handshake and queue bookkeeping; a redirect overrides both enqueue and dequeue.
  always_comb begin
    w_ack        = imem_ack && r_req;
    w_valid      = (r_count != '0);
    w_enq        = w_ack && !r_discard && !PCSrcE;
    w_deq        = w_valid && !StallF && !PCSrcE;
    w_slot_free  = !r_req || w_ack;
    w_target     = PCTargetE & ~word_width'(3);
    w_count_next = PCSrcE ? '0 : (r_count + CW'(w_enq) - CW'(w_deq));
    w_issue      = w_slot_free && (w_count_next < CW'(depth));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_addr     <= reset_pc;
      r_fetch_pc <= reset_pc;
      r_count    <= '0;
      r_discard  <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_count <= w_count_next;
      if (PCSrcE) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_deq) r_head <= r_head + AW'(1);
        if (w_enq) r_tail <= r_tail + AW'(1);
      end

      if (PCSrcE) begin
        if (w_slot_free) begin
          r_req      <= 1'b1;
          r_addr     <= w_target;
          r_fetch_pc <= w_target + STEP;
          r_discard  <= 1'b0;
        end else begin
          // Outstanding request must complete untouched; its data is dropped later.
          r_discard  <= 1'b1;
          r_fetch_pc <= w_target;
        end
      end else begin
        if (w_ack) r_discard <= 1'b0;
        if (w_issue) begin
          r_req      <= 1'b1;
          r_addr     <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + STEP;
        end else if (w_ack) begin
          r_req <= 1'b0;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_pc_q[r_tail]    <= r_addr;
      r_instr_q[r_tail] <= imem_rdata;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign validF    = w_valid;
  assign instrF    = w_valid ? r_instr_q[r_head] : '0;
  assign PCF       = w_valid ? r_pc_q[r_head] : '0;
  assign PCPlus4F  = w_valid ? (r_pc_q[r_head] + STEP) : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: vector table, directed latency/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  logic        zw;
  logic        ack_drv;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_ack   = zw ? imem_req : ack_drv;
  assign imem_rdata = mem_word(imem_addr);

  fetch_prefetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .validF(validF), .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ep;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] ep, input logic er, input logic [31:0] ea);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.tgt = tgt;
    v.ev = ev; v.ep = ep; v.er = er; v.ea = ea;
    vq.push_back(v);
  endtask

  task automatic check_out(input string name, input logic zero, input logic ev, input logic [31:0] ep,
                           input logic er, input logic [31:0] ea);
    logic ok;
    ok = (validF === ev) && (imem_req === er);
    if (er || zero) ok = ok && (imem_addr === ea);
    if (ev) ok = ok && (PCF === ep) && (instrF === mem_word(ep)) && (PCPlus4F === 32'(ep + 32'd4));
    if (zero) ok = ok && (PCF === 32'd0) && (instrF === 32'd0) && (PCPlus4F === 32'd0);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h pc4=%h req=%0b addr=%h, want valid=%0b pc=%h req=%0b addr=%h",
               name, validF, PCF, instrF, PCPlus4F, imem_req, imem_addr, ev, ep, er, ea);
    end
  endtask

  task automatic cyc(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt,
                     input logic ack);
    reset = rst; StallF = stall; PCSrcE = redir; PCTargetE = tgt; ack_drv = ack;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of buffered PCs plus the request/redirect state.
  logic [31:0] m_q[$];
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  logic        m_disc;

  task automatic model_step(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt,
                            input logic ack);
    logic        acked;
    logic        free;
    logic [31:0] t;
    if (rst) begin
      m_q.delete(); m_req = 1'b0; m_addr = 32'd0; m_fpc = 32'd0; m_disc = 1'b0;
      return;
    end
    acked = ack && m_req;
    free  = !m_req || acked;
    t     = tgt & 32'hFFFF_FFFC;
    if (redir) begin
      m_q.delete();
      if (free) begin
        m_req = 1'b1; m_addr = t; m_fpc = t + 32'd4; m_disc = 1'b0;
      end else begin
        m_disc = 1'b1; m_fpc = t;
      end
    end else begin
      if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
      if (acked && !m_disc) m_q.push_back(m_addr);
      if (acked) m_disc = 1'b0;
      if (free && m_q.size() < 4) begin
        m_req = 1'b1; m_addr = m_fpc; m_fpc = m_fpc + 32'd4;
      end else if (acked) begin
        m_req = 1'b0;
      end
    end
  endtask

  int n_print = 0;

  task automatic check_model(input int cycle);
    logic        ok;
    logic [31:0] hp;
    hp = (m_q.size() > 0) ? m_q[0] : 32'd0;
    ok = (validF === (m_q.size() != 0)) && (imem_req === m_req);
    if (m_req) ok = ok && (imem_addr === m_addr);
    if (m_q.size() > 0)
      ok = ok && (PCF === hp) && (instrF === mem_word(hp)) && (PCPlus4F === 32'(hp + 32'd4));
    n_total++;
    if (!ok) begin
      n_bad++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL rand%0d: got valid=%0b pc=%h instr=%h req=%0b addr=%h, want valid=%0b pc=%h req=%0b addr=%h",
                 cycle, validF, PCF, instrF, imem_req, imem_addr, (m_q.size() != 0), hp, m_req, m_addr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0; ack_drv = 1'b0; zw = 1'b1;

    // Zero-wait memory: streaming, redirects, stall-until-full, reset, wrap.
    add(1,0,0,32'h0,   0,32'h0,   0,32'h0);
    add(0,0,0,32'h0,   0,32'h0,   1,32'h0);
    add(0,0,0,32'h0,   1,32'h0,   1,32'h4);
    add(0,0,0,32'h0,   1,32'h4,   1,32'h8);
    add(0,0,0,32'h0,   1,32'h8,   1,32'hC);
    add(0,0,1,32'h100, 0,32'h0,   1,32'h100);
    add(0,0,0,32'h0,   1,32'h100, 1,32'h104);
    add(0,0,0,32'h0,   1,32'h104, 1,32'h108);
    add(0,1,1,32'h203, 0,32'h0,   1,32'h200);
    add(0,0,0,32'h0,   1,32'h200, 1,32'h204);
    add(0,0,0,32'h0,   1,32'h204, 1,32'h208);
    add(0,1,0,32'h0,   1,32'h204, 1,32'h20C);
    add(0,1,0,32'h0,   1,32'h204, 1,32'h210);
    add(0,1,0,32'h0,   1,32'h204, 0,32'h210);
    add(0,1,0,32'h0,   1,32'h204, 0,32'h210);
    add(0,1,0,32'h0,   1,32'h204, 0,32'h210);
    add(0,1,0,32'h0,   1,32'h204, 0,32'h210);
    add(0,0,0,32'h0,   1,32'h208, 1,32'h214);
    add(0,0,0,32'h0,   1,32'h20C, 1,32'h218);
    add(0,0,0,32'h0,   1,32'h210, 1,32'h21C);
    add(0,0,0,32'h0,   1,32'h214, 1,32'h220);
    add(1,0,0,32'h0,   0,32'h0,   0,32'h0);
    add(0,0,0,32'h0,   0,32'h0,   1,32'h0);
    add(0,0,1,32'hFFFF_FFFC, 0,32'h0, 1,32'hFFFF_FFFC);
    add(0,0,0,32'h0,   1,32'hFFFF_FFFC, 1,32'h0);
    add(0,0,0,32'h0,   1,32'h0,   1,32'h4);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].stall, vq[i].redir, vq[i].tgt, 1'b0);
      check_out($sformatf("vec%0d", i), vq[i].rst, vq[i].ev, vq[i].ep, vq[i].er, vq[i].ea);
    end

    // Slow memory: redirect while request to 0x10 is outstanding.
    zw = 1'b0;
    cyc(1,0,0,32'h0,0);
    cyc(0,0,1,32'h10,0);  check_out("lat_req10",   0, 0, 32'h0,  1, 32'h10);
    cyc(0,0,1,32'h40,0);  check_out("lat_hold1",   0, 0, 32'h0,  1, 32'h10);
    cyc(0,0,0,32'h0,0);   check_out("lat_hold2",   0, 0, 32'h0,  1, 32'h10);
    cyc(0,0,0,32'h0,1);   check_out("lat_drop",    0, 0, 32'h0,  1, 32'h40);
    cyc(0,0,0,32'h0,0);   check_out("lat_wait1",   0, 0, 32'h0,  1, 32'h40);
    cyc(0,0,0,32'h0,0);   check_out("lat_wait2",   0, 0, 32'h0,  1, 32'h40);
    cyc(0,0,0,32'h0,1);   check_out("lat_first40", 0, 1, 32'h40, 1, 32'h44);

    // Reset with three buffered entries and a request outstanding, ack in the reset cycle.
    cyc(1,0,0,32'h0,0);
    cyc(0,1,0,32'h0,0);   check_out("rst_issue",   0, 0, 32'h0,  1, 32'h0);
    cyc(0,1,0,32'h0,1);
    cyc(0,1,0,32'h0,1);
    cyc(0,1,0,32'h0,1);   check_out("rst_cnt3",    0, 1, 32'h0,  1, 32'hC);
    cyc(0,1,0,32'h0,0);   check_out("rst_pending", 0, 1, 32'h0,  1, 32'hC);
    cyc(1,1,0,32'h0,1);   check_out("rst_clear",   1, 0, 32'h0,  0, 32'h0);
    cyc(0,0,0,32'h0,0);   check_out("rst_fresh",   0, 0, 32'h0,  1, 32'h0);
    cyc(0,0,0,32'h0,1);   check_out("rst_first",   0, 1, 32'h0,  1, 32'h4);

    // Randomized traffic: zero-wait phase, then random-latency phase.
    cyc(1,0,0,32'h0,0);
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_stall, r_redir, r_ack;
      logic [31:0] r_tgt;
      check_model(i);
      r_rst   = ($urandom_range(0, 199) == 0);
      r_stall = ($urandom_range(0, 9) < 3);
      r_redir = ($urandom_range(0, 15) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_ack   = (i < 1500) ? m_req : ($urandom_range(0, 9) < 4);
      model_step(r_rst, r_stall, r_redir, r_tgt, r_ack);
      cyc(r_rst, r_stall, r_redir, r_tgt, r_ack);
    end
    check_model(3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
